// File: rtl/add_64_seq.sv
// Multi-cycle 64-bit adder: adds CHUNK_W bits per cycle, LSB chunk first,
// and reports sum plus overflow/carry/zero/sign flags with a one-cycle done pulse.
module add_64_seq #(
    parameter int CHUNK_W = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic        busy,
    output logic        done,
    output logic [63:0] sum,
    output logic        overflow,
    output logic        cf,
    output logic        zf,
    output logic        sf
);

    localparam int NCHUNK = 64 / CHUNK_W;
    localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [NCHUNK-1:0][CHUNK_W-1:0] a_q, b_q, sum_q, sum_nxt;
    logic [KW-1:0]                  k;
    logic                           carry;
    logic                           accept;
    logic                           last;
    logic [CHUNK_W:0]               chunk_sum;

    // Start is honoured only while no addition is in flight.
    always_comb begin
        accept    = (state != RUN) && start;
        last      = (k == KW'(NCHUNK - 1));
        chunk_sum = {1'b0, a_q[k]} + {1'b0, b_q[k]} + (CHUNK_W + 1)'(carry);
        sum_nxt   = sum_q;
        sum_nxt[k] = chunk_sum[CHUNK_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start ? RUN : IDLE;
            RUN:     state_nxt = last ? DONE : RUN;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    // Operand latches carry no reset; they are always reloaded before use.
    always_ff @(posedge clk) begin
        if (rst_n && accept) begin
            a_q <= a;
            b_q <= b;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            k        <= '0;
            carry    <= 1'b0;
            sum_q    <= '0;
            overflow <= 1'b0;
            cf       <= 1'b0;
            zf       <= 1'b0;
            sf       <= 1'b0;
        end else if (accept) begin
            k     <= '0;
            carry <= 1'b0;
        end else if (state == RUN) begin
            sum_q <= sum_nxt;
            carry <= chunk_sum[CHUNK_W];
            k     <= last ? '0 : k + KW'(1);
            // Flags move only when the final chunk lands, so they stay stable through RUN.
            if (last) begin
                overflow <= (a_q[NCHUNK-1][CHUNK_W-1] == b_q[NCHUNK-1][CHUNK_W-1]) &&
                            (sum_nxt[NCHUNK-1][CHUNK_W-1] != a_q[NCHUNK-1][CHUNK_W-1]);
                cf       <= chunk_sum[CHUNK_W];
                zf       <= (sum_nxt == '0);
                sf       <= sum_nxt[NCHUNK-1][CHUNK_W-1];
            end
        end
    end

    assign sum = sum_q;

endmodule
